// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with a 2-bit saturating-counter BHT for fetch prediction.
// Optional resolve/mispredict statistics counters are enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_pred_taken,
    input  logic            i_valid,
    input  logic            i_is_branch,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_taken,
    input  logic            i_pred_taken,
    output logic            o_redirect,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispred_cnt
`else
    output logic [XLEN-1:0] o_redirect_pc
`endif
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] fetch_idx;
    logic [BHT_IDX_W-1:0] resolve_idx;
    logic                 resolve;
    logic                 mispred;
    logic [XLEN-1:0]      actual_npc;
    logic [1:0]           ctr_q;
    logic [1:0]           ctr_d;
    logic                 redirect_q;
    logic [XLEN-1:0]      redirect_pc_q;
    logic                 unused_fetch_bits;

    assign fetch_idx         = i_fetch_pc[BHT_IDX_W+1:2];
    assign resolve_idx       = i_pc[BHT_IDX_W+1:2];
    assign unused_fetch_bits = ^{i_fetch_pc[XLEN-1:BHT_IDX_W+2], i_fetch_pc[1:0]};

    // Read is taken from the registered array, so a same-cycle train is not visible yet.
    assign o_pred_taken = bht_q[fetch_idx][1];

    // Wrong-path instructions behind a redirect are squashed; gating with resolve
    // also keeps an unknown i_taken/i_pred_taken out of every register.
    always_comb begin
        resolve    = i_valid & i_is_branch & ~redirect_q;
        mispred    = resolve & (i_taken != i_pred_taken);
        actual_npc = i_taken ? (i_pc + i_imm) : (i_pc + XLEN'(4));
        ctr_q      = bht_q[resolve_idx];
        ctr_d      = ctr_q;
        if (i_taken) begin
            if (ctr_q != 2'd3) ctr_d = ctr_q + 2'd1;
        end else begin
            if (ctr_q != 2'd0) ctr_d = ctr_q - 2'd1;
        end
    end

    // NOTE: the BHT must reset to a known weakly-not-taken state, so this small
    // array is built from flops with an async reset rather than an SRAM macro.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            bht_q[resolve_idx] <= ctr_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= mispred;
            if (mispred) redirect_pc_q <= actual_npc;
        end
    end

    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve && branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispred && mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by random
// traffic, all checked against a behavioural model of the predictor and redirect.
module tb_branch_resolve;

    localparam int XLEN = 32;
    localparam int NENT = 16;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [XLEN-1:0] i_fetch_pc;
    logic            o_pred_taken;
    logic            i_valid;
    logic            i_is_branch;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_imm;
    logic            i_taken;
    logic            i_pred_taken;
    logic            o_redirect;
    logic [XLEN-1:0] o_redirect_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0]     o_branch_cnt;
    logic [31:0]     o_mispred_cnt;
`endif

    branch_resolve #(.XLEN(XLEN), .BHT_ENTRIES(NENT)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_fetch_pc    (i_fetch_pc),
        .o_pred_taken  (o_pred_taken),
        .i_valid       (i_valid),
        .i_is_branch   (i_is_branch),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_taken       (i_taken),
        .i_pred_taken  (i_pred_taken),
        .o_redirect    (o_redirect),
`ifdef BRANCH_RESOLVE_STATS_EN
        .o_redirect_pc (o_redirect_pc),
        .o_branch_cnt  (o_branch_cnt),
        .o_mispred_cnt (o_mispred_cnt)
`else
        .o_redirect_pc (o_redirect_pc)
`endif
    );

    always #5 i_clk = ~i_clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: counters as plain integers 0..3, counts as integers.
    int          m_ctr [NENT];
    bit          m_redir;
    logic [31:0] m_rpc;
    int          m_bcnt;
    int          m_mcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_redir = 1'b0;
        m_rpc   = '0;
        m_bcnt  = 0;
        m_mcnt  = 0;
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc, input logic [31:0] imm,
                         input logic t, input logic p, input logic [31:0] fpc);
        i_valid      = v;
        i_is_branch  = br;
        i_pc         = pc;
        i_imm        = imm;
        i_taken      = t;
        i_pred_taken = p;
        i_fetch_pc   = fpc;
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'bx, 1'bx, fpc);
    endtask

    function automatic int entry_of(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    // Checks the combinational prediction, advances the model by one edge,
    // then checks the registered outputs just after that edge.
    task automatic cycle(input string tag);
        bit          resolve;
        bit          mis;
        bit          t;
        int          e;
        logic [31:0] npc;
        #1;
        check({tag, ".pred"}, {31'b0, o_pred_taken}, (m_ctr[entry_of(i_fetch_pc)] >= 2) ? 32'd1 : 32'd0);
        resolve = (i_valid === 1'b1) && (i_is_branch === 1'b1) && !m_redir;
        mis     = 1'b0;
        npc     = m_rpc;
        if (resolve) begin
            t = (i_taken === 1'b1);
            e = entry_of(i_pc);
            mis = (t != (i_pred_taken === 1'b1));
            m_ctr[e] = t ? ((m_ctr[e] < 3) ? m_ctr[e] + 1 : 3) : ((m_ctr[e] > 0) ? m_ctr[e] - 1 : 0);
            if (mis) npc = t ? i_pc + i_imm : i_pc + 32'd4;
            m_bcnt++;
            if (mis) m_mcnt++;
        end
        @(posedge i_clk);
        #1;
        m_redir = mis;
        m_rpc   = npc;
        check({tag, ".redir"}, {31'b0, o_redirect}, {31'b0, m_redir});
        check({tag, ".rpc"}, o_redirect_pc, m_rpc);
`ifdef BRANCH_RESOLVE_STATS_EN
        check({tag, ".bcnt"}, o_branch_cnt, m_bcnt);
        check({tag, ".mcnt"}, o_mispred_cnt, m_mcnt);
`endif
    endtask

    initial begin
        bit p;
        // Test 1: reset state
        i_rst_n = 1'b0;
        idle(32'h100);
        model_reset();
        #12;
        check("t1.pred", {31'b0, o_pred_taken}, 32'd0);
        check("t1.redir", {31'b0, o_redirect}, 32'd0);
        check("t1.rpc", o_redirect_pc, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Test 2: first mispredict redirects to the taken target
        drive(1, 1, 32'h100, 32'h20, 1, 0, 32'h100);
        cycle("t2a");
        check("t2.redir_hi", {31'b0, o_redirect}, 32'd1);
        check("t2.target", o_redirect_pc, 32'h120);
        idle(32'h100);
        cycle("t2b");
        check("t2.redir_lo", {31'b0, o_redirect}, 32'd0);
        check("t2.pred_now", {31'b0, o_pred_taken}, 32'd1);

        // Test 3: saturate then one not-taken mispredict
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h100, 32'h20, 1, 1, 32'h100);
            cycle("t3sat");
        end
        drive(1, 1, 32'h100, 32'h20, 0, 1, 32'h100);
        cycle("t3nt");
        check("t3.fallthru", o_redirect_pc, 32'h104);
        idle(32'h100);
        cycle("t3c");
        check("t3.pred_still", {31'b0, o_pred_taken}, 32'd1);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("t3.bcnt6", o_branch_cnt, 32'd6);
        check("t3.mcnt2", o_mispred_cnt, 32'd2);
`endif

        // Test 4: instruction right behind a redirect is squashed
        drive(1, 1, 32'h208, 32'h40, 1, 0, 32'h20C);
        cycle("t4a");
        check("t4.target", o_redirect_pc, 32'h248);
        drive(1, 1, 32'h20C, 32'h10, 0, 1, 32'h20C);
        cycle("t4b");
        check("t4.no_second", {31'b0, o_redirect}, 32'd0);
        check("t4.rpc_held", o_redirect_pc, 32'h248);
        idle(32'h20C);
        cycle("t4c");
        check("t4.bht_same", {31'b0, o_pred_taken}, 32'd0);

        // Test 5: target address wraps
        drive(1, 1, 32'hFFFF_FFFC, 32'h8, 1, 0, 32'h3C);
        cycle("t5");
        check("t5.wrap", o_redirect_pc, 32'h4);
        idle(32'h3C);
        cycle("t5b");

        // Test 6: non-branch with unknown outcome, then reset mid-pulse
        drive(1, 0, 32'h100, 32'h20, 1'bx, 1'bx, 32'h100);
        cycle("t6a");
        check("t6.no_redir", {31'b0, o_redirect}, 32'd0);
        idle(32'h100);
        cycle("t6b");
        check("t6.bht_same", {31'b0, o_pred_taken}, 32'd1);
        drive(1, 1, 32'h300, 32'h4, 0, 1, 32'h300);
        cycle("t6c");
        check("t6.pulse", {31'b0, o_redirect}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check("t6.rst_redir", {31'b0, o_redirect}, 32'd0);
        check("t6.rst_rpc", o_redirect_pc, 32'h0);
        check("t6.rst_bht", {31'b0, o_pred_taken}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("t6.rst_bcnt", o_branch_cnt, 32'd0);
`endif
        idle(32'h300);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle("t6d");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            p = ($urandom_range(0, 1) == 1) ? (m_ctr[entry_of(i_pc)] >= 2) : 1'($urandom);
            drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom), 1'b0, $urandom);
            i_pred_taken = ($urandom_range(0, 1) == 1) ? (m_ctr[entry_of(i_pc)] >= 2) : p;
            if (!(i_valid && i_is_branch)) begin
                i_taken      = 1'bx;
                i_pred_taken = 1'bx;
            end
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
